// File: rtl/i8008_pkg.sv
// Shared types for the i8008 core and its bus controller.
// Provides the core T-state encoding, bus cycle types and I/O constants.
package i8008_pkg;

    typedef enum logic [2:0] {
        T1      = 3'b010,
        T1I     = 3'b110,
        T2      = 3'b100,
        WAIT    = 3'b000,
        T3      = 3'b001,
        STOPPED = 3'b011,
        T4      = 3'b111,
        T5      = 3'b101
    } state_t;

    typedef enum logic [1:0] {
        PCI = 2'b00,
        PCR = 2'b10,
        PCC = 2'b01,
        PCW = 2'b11
    } cycle_t;

    // Port numbers at or above this base are OUT ports, below are INP.
    localparam logic [4:0] IO_OUT_BASE = 5'd8;

endpackage

// File: rtl/i8008_ram.sv
// Byte-wide RAM with one registered read port and one write port.
// Ports: clk/rst, rd_en/rd_addr/rd_data, ld_* preload, wr_* core write.
module i8008_ram #(
    parameter int MEM_WORDS = 1024,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data
);

    logic [7:0] mem_q [MEM_WORDS];
    logic [7:0] rd_data_q;

    // Preload owns the write port whenever it is active.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/i8008_bus_ctrl.sv
// Bus controller decoding i8008 T-states into memory and I/O cycles.
// Ports: clk/rst, state/D_out from core, D_in/READY to core, ld_* preload, io_* port I/O, halted.
module i8008_bus_ctrl
    import i8008_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  state_t      state,
    input  logic [7:0]  D_out,
    output logic [7:0]  D_in,
    output logic        READY,
    input  logic        ld_en,
    input  logic [13:0] ld_addr,
    input  logic [7:0]  ld_data,
    input  logic [7:0]  io_in,
    output logic        io_wr,
    output logic [4:0]  io_port,
    output logic [7:0]  io_data,
    output logic        halted
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);
    localparam logic [13:0] ADDR_MASK = 14'(MEM_WORDS - 1);

    logic [7:0]  addr_l_q, addr_l_d;
    logic [5:0]  addr_h_q, addr_h_d;
    cycle_t      cyc_q, cyc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        io_wr_q, io_wr_d;
    logic [4:0]  io_port_q, io_port_d;
    logic [7:0]  io_data_q, io_data_d;
    logic        halted_q, halted_d;
    logic [7:0]  inp_q, inp_d;
    logic        sel_io_q, sel_io_d;

    logic        bus_rd;
    cycle_t      cur_cyc;
    logic [5:0]  cur_h;
    logic [13:0] cur_addr;
    logic [13:0] wr_addr;
    logic        is_inp;
    logic        out_port;
    logic        rd_ram;
    logic        wr_ram;
    logic [7:0]  ram_data;
    logic [13:0] unused_hi;

    // During T2 the cycle type and high address are still only on D_out.
    always_comb begin
        bus_rd   = (state == T2) || (state == WAIT);
        cur_cyc  = (state == T2) ? cycle_t'(D_out[7:6]) : cyc_q;
        cur_h    = (state == T2) ? D_out[5:0] : addr_h_q;
        cur_addr = {cur_h, addr_l_q};
        wr_addr  = {addr_h_q, addr_l_q};
        is_inp   = cur_h[5:1] < IO_OUT_BASE;
        out_port = addr_h_q[5:1] >= IO_OUT_BASE;
        rd_ram   = bus_rd && ((cur_cyc == PCI) || (cur_cyc == PCR));
    end

    always_comb begin
        addr_l_d  = addr_l_q;
        addr_h_d  = addr_h_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        io_wr_d   = 1'b0;
        io_port_d = io_port_q;
        io_data_d = io_data_q;
        inp_d     = inp_q;
        sel_io_d  = sel_io_q;
        halted_d  = (state == STOPPED);
        wr_ram    = 1'b0;

        if (bus_rd && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
        end

        case (state)
            T1: begin
                addr_l_d = D_out;
                cnt_d    = '0;
            end
            T2: begin
                cyc_d    = cycle_t'(D_out[7:6]);
                addr_h_d = D_out[5:0];
            end
            T3: begin
                if (cyc_q == PCW) begin
                    wr_ram = 1'b1;
                end
                if ((cyc_q == PCC) && out_port) begin
                    io_wr_d   = 1'b1;
                    io_port_d = addr_h_q[5:1];
                    io_data_d = addr_l_q;
                end
            end
            default: ;
        endcase

        if (bus_rd && (cur_cyc == PCC) && is_inp) begin
            inp_d    = io_in;
            sel_io_d = 1'b1;
        end
        if (rd_ram) begin
            sel_io_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_l_q  <= '0;
            addr_h_q  <= '0;
            cyc_q     <= PCI;
            cnt_q     <= '0;
            io_wr_q   <= 1'b0;
            io_port_q <= '0;
            io_data_q <= '0;
            halted_q  <= 1'b0;
            inp_q     <= '0;
            sel_io_q  <= 1'b0;
        end else begin
            addr_l_q  <= addr_l_d;
            addr_h_q  <= addr_h_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            io_wr_q   <= io_wr_d;
            io_port_q <= io_port_d;
            io_data_q <= io_data_d;
            halted_q  <= halted_d;
            inp_q     <= inp_d;
            sel_io_q  <= sel_io_d;
        end
    end

    // Address bits above the RAM size alias away.
    assign unused_hi = (cur_addr | wr_addr | ld_addr) & ~ADDR_MASK;

    i8008_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_ram),
        .rd_addr (cur_addr[AW-1:0]),
        .rd_data (ram_data),
        .ld_en   (ld_en),
        .ld_addr (ld_addr[AW-1:0]),
        .ld_data (ld_data),
        .wr_en   (wr_ram && rst),
        .wr_addr (wr_addr[AW-1:0]),
        .wr_data (D_out)
    );

    assign READY   = bus_rd && (cnt_q >= WS);
    assign D_in    = sel_io_q ? inp_q : ram_data;
    assign io_wr   = io_wr_q;
    assign io_port = io_port_q;
    assign io_data = io_data_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_i8008_bus_ctrl.sv
// Scoreboard bench for i8008_bus_ctrl: dut0 has 1024 bytes and no waits,
// dut1 has 16384 bytes and three wait states.
module tb_i8008_bus_ctrl;
    import i8008_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    state_t      st      [2];
    logic [7:0]  dout    [2];
    logic [7:0]  din     [2];
    logic        rdy     [2];
    logic        ld_en   [2];
    logic [13:0] ld_addr [2];
    logic [7:0]  ld_data [2];
    logic        io_wr   [2];
    logic [4:0]  io_port [2];
    logic [7:0]  io_data [2];
    logic        halted  [2];
    logic [7:0]  io_in;

    i8008_bus_ctrl #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst[0]), .state(st[0]), .D_out(dout[0]),
        .D_in(din[0]), .READY(rdy[0]), .ld_en(ld_en[0]),
        .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .io_in(io_in),
        .io_wr(io_wr[0]), .io_port(io_port[0]), .io_data(io_data[0]),
        .halted(halted[0])
    );

    i8008_bus_ctrl #(.MEM_WORDS(16384), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst[1]), .state(st[1]), .D_out(dout[1]),
        .D_in(din[1]), .READY(rdy[1]), .ld_en(ld_en[1]),
        .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .io_in(io_in),
        .io_wr(io_wr[1]), .io_port(io_port[1]), .io_data(io_data[1]),
        .halted(halted[1])
    );

    typedef struct { bit chk; logic [7:0] val; } rd_t;
    typedef struct { logic [4:0] port; logic [7:0] data; } io_t;

    rd_t rdq0[$];
    rd_t rdq1[$];
    io_t ioq0[$];
    io_t ioq1[$];

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;
    bit fin    = 1'b0;

    int     ws_exp [2] = '{0, 3};
    int     wcm    [2];
    int     nwait  [2];
    int     rc     [2];
    state_t pst    [2];
    logic   prst   [2];

    function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endfunction

    // Monitor: samples mid-cycle, pops expectations when the DUT presents data.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst[k]) begin
                if (rc[k] >= 1) begin
                    chk("rst_D_in", k, din[k], 0);
                    chk("rst_READY", k, rdy[k], 0);
                    chk("rst_io_wr", k, io_wr[k], 0);
                    chk("rst_io_port", k, io_port[k], 0);
                    chk("rst_io_data", k, io_data[k], 0);
                    chk("rst_halted", k, halted[k], 0);
                end
                rc[k]++;
                wcm[k]   = 0;
                nwait[k] = 0;
            end else begin
                rc[k] = 0;
                chk("halted", k, halted[k],
                    32'(prst[k] === 1'b1 && pst[k] == STOPPED));
                case (st[k])
                    T1: begin
                        wcm[k]   = 0;
                        nwait[k] = 0;
                        chk("READY_T1", k, rdy[k], 0);
                    end
                    T2, WAIT: begin
                        if (st[k] == WAIT) nwait[k]++;
                        chk("READY_wait", k, rdy[k], 32'(wcm[k] >= ws_exp[k]));
                        if (wcm[k] < 15) wcm[k]++;
                    end
                    T3: begin
                        rd_t e;
                        chk("READY_T3", k, rdy[k], 0);
                        chk("wait_count", k, nwait[k], ws_exp[k]);
                        if ((k == 0 && rdq0.size() == 0) ||
                            (k == 1 && rdq1.size() == 0)) begin
                            chk("rd_underflow", k, 1, 0);
                        end else begin
                            e = (k == 0) ? rdq0.pop_front() : rdq1.pop_front();
                            if (e.chk) chk("D_in_T3", k, din[k], e.val);
                        end
                    end
                    default: chk("READY_idle", k, rdy[k], 0);
                endcase
                if (io_wr[k]) begin
                    io_t o;
                    if ((k == 0 && ioq0.size() == 0) ||
                        (k == 1 && ioq1.size() == 0)) begin
                        chk("io_wr_unexpected", k, 1, 0);
                    end else begin
                        o = (k == 0) ? ioq0.pop_front() : ioq1.pop_front();
                        chk("io_port", k, io_port[k], o.port);
                        chk("io_data", k, io_data[k], o.data);
                    end
                end
            end
            pst[k]  = st[k];
            prst[k] = rst[k];
        end
        if (done && !fin) begin
            fin = 1'b1;
            chk("rd_left", 0, rdq0.size(), 0);
            chk("rd_left", 1, rdq1.size(), 0);
            chk("io_left", 0, ioq0.size(), 0);
            chk("io_left", 1, ioq1.size(), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int k, input logic [13:0] a, input logic [7:0] d);
        ld_en[k]   = 1'b1;
        ld_addr[k] = a;
        ld_data[k] = d;
        tick();
        ld_en[k] = 1'b0;
    endtask

    // Plays the core through one machine cycle, honouring READY.
    task automatic run_cycle(input int k, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input bit c, input logic [7:0] ev,
                             input bit ld, input logic [13:0] la, input logic [7:0] lv);
        rd_t e;
        int  n;
        e.chk = c;
        e.val = ev;
        if (k == 0) rdq0.push_back(e);
        else        rdq1.push_back(e);
        st[k]   = T1;
        dout[k] = b1;
        tick();
        st[k]   = T2;
        dout[k] = b2;
        #1;
        n = 0;
        while (!rdy[k] && n < 40) begin
            tick();
            st[k] = WAIT;
            n++;
            #1;
        end
        tick();
        st[k]   = T3;
        dout[k] = b3;
        if (ld) begin
            ld_en[k]   = 1'b1;
            ld_addr[k] = la;
            ld_data[k] = lv;
        end
        tick();
        ld_en[k] = 1'b0;
        st[k]    = T4;
        tick();
    endtask

    initial begin
        io_t o;
        for (int k = 0; k < 2; k++) begin
            rst[k]     = 1'b0;
            st[k]      = T4;
            dout[k]    = '0;
            ld_en[k]   = 1'b0;
            ld_addr[k] = '0;
            ld_data[k] = '0;
        end
        io_in = '0;
        tick();
        preload(0, 14'h0000, 8'h08);
        preload(0, 14'h0001, 8'hFF);
        preload(1, 14'h0100, 8'h11);
        tick();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        tick();

        run_cycle(0, 8'h00, 8'h00, 8'h00, 1, 8'h08, 0, 0, 0);
        run_cycle(0, 8'h01, 8'h00, 8'h00, 1, 8'hFF, 0, 0, 0);
        run_cycle(0, 8'h00, 8'h04, 8'h00, 1, 8'h08, 0, 0, 0);
        run_cycle(0, 8'h12, 8'hC0, 8'h3C, 0, 8'h00, 0, 0, 0);
        run_cycle(0, 8'h12, 8'h00, 8'h00, 1, 8'h3C, 0, 0, 0);
        run_cycle(0, 8'h12, 8'hC4, 8'h5A, 0, 8'h00, 0, 0, 0);
        run_cycle(0, 8'h12, 8'h80, 8'h00, 1, 8'h5A, 0, 0, 0);
        run_cycle(0, 8'h20, 8'hC0, 8'h99, 0, 8'h00, 1, 14'h0020, 8'h66);
        run_cycle(0, 8'h20, 8'h80, 8'h00, 1, 8'h66, 0, 0, 0);
        o.port = 5'd9;
        o.data = 8'h5C;
        ioq0.push_back(o);
        run_cycle(0, 8'h5C, 8'h52, 8'h00, 0, 8'h00, 0, 0, 0);
        io_in = 8'h77;
        run_cycle(0, 8'h00, 8'h46, 8'h00, 1, 8'h77, 0, 0, 0);
        io_in = 8'h00;
        run_cycle(0, 8'h01, 8'h04, 8'h00, 1, 8'hFF, 0, 0, 0);
        st[0] = STOPPED;
        repeat (3) tick();
        st[0] = T4;
        tick();

        run_cycle(1, 8'h34, 8'hD2, 8'hA5, 0, 8'h00, 0, 0, 0);
        run_cycle(1, 8'h34, 8'h92, 8'h00, 1, 8'hA5, 0, 0, 0);
        st[1]   = T1;
        dout[1] = 8'h00;
        tick();
        st[1]   = T2;
        dout[1] = 8'hC1;
        tick();
        st[1]   = WAIT;
        dout[1] = 8'hEE;
        rst[1]  = 1'b0;
        tick();
        st[1] = T1;
        tick();
        rst[1] = 1'b1;
        st[1]  = T4;
        tick();
        run_cycle(1, 8'h00, 8'h81, 8'h00, 1, 8'h11, 0, 0, 0);

        done = 1'b1;
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
